cpu_step_ctrl: RTL and testbench

//   Consumes the toggle output t of the clock divider and turns it into a one-clk-wide
//   CPU enable pulse. Supports free-run, single-step (debounced push-button) and sticky halt.

---
 rtl/cpu_step_ctrl_pkg.sv | 18 +
 rtl/cpu_step_ctrl_button_debouncer.sv | 55 +++++
 rtl/cpu_step_ctrl.sv | 139 +++++++++++++
 tb/tb_cpu_step_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_step_ctrl_pkg.sv
// Shared definitions for the CPU step controller: FSM state encodings
// (also consumed by CPU debug/LED logic) and small edge helpers.
package cpu_step_ctrl_pkg;

  // FSM states; encodings are visible on the state output port.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_ARMED  = 2'd2,
    ST_HALTED = 2'd3
  } step_state_e;

  // Rising-edge detect between a current sample and its registered copy.
  function automatic logic rise_edge(input logic cur, input logic prev);
    return cur & ~prev;
  endfunction

endpackage

// File: rtl/cpu_step_ctrl_button_debouncer.sv
// Push-button conditioner: 2-FF synchronizer, stability counter and
// a one-cycle press pulse on an accepted 0->1 transition. Releases are
// accepted silently. Reusable for any raw board button.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic press
);

  localparam int              DW      = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DW-1:0]   DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DW-1:0]   DB_ZERO = {DW{1'b0}};
  localparam logic [DW-1:0]   DB_ONE  = DW'(1);

  logic          sync1_r;
  logic          sync2_r;
  logic          stable_r;
  logic          press_r;
  logic [DW-1:0] db_cnt_r;

  // Synchronize the raw button, then accept a new level only after it has
  // disagreed with the accepted level for DEBOUNCE_CYCLES consecutive cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_r  <= 1'b0;
      sync2_r  <= 1'b0;
      stable_r <= 1'b0;
      press_r  <= 1'b0;
      db_cnt_r <= DB_ZERO;
    end else begin
      sync1_r <= btn_raw;
      sync2_r <= sync1_r;
      press_r <= 1'b0;
      if (sync2_r != stable_r) begin
        if (db_cnt_r == DB_LAST) begin
          stable_r <= sync2_r;
          db_cnt_r <= DB_ZERO;
          // Only a newly accepted high level is a press.
          press_r  <= sync2_r;
        end else begin
          db_cnt_r <= db_cnt_r + DB_ONE;
        end
      end else begin
        // Any agreement restarts the stability window.
        db_cnt_r <= DB_ZERO;
      end
    end
  end

  assign press = press_r;

endmodule

// File: rtl/cpu_step_ctrl.sv
// CPU step controller: turns the clock divider toggle t into one-clk-wide
// CPU enable pulses. Supports free-run, debounced single-step and a sticky
// halt that only reset clears. Everything runs on the fast clk.
module cpu_step_ctrl
  import cpu_step_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             t,
  input  logic             mode_run,
  input  logic             step_btn,
  input  logic             halt,
  output logic             cpu_en,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] step_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             t_q_r;
  logic             tick_s;
  logic             press_s;
  step_state_e      state_r;
  step_state_e      state_next_s;
  logic             pulse_s;
  logic             cpu_en_r;
  logic [CNT_W-1:0] step_cnt_r;

  button_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_step_debouncer (
    .clk     (clk),
    .reset   (reset),
    .btn_raw (step_btn),
    .press   (press_s)
  );

  // Register t so a rising edge of the divider toggle yields a single tick.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      t_q_r <= 1'b0;
    end else begin
      t_q_r <= t;
    end
  end

  assign tick_s = rise_edge(t, t_q_r);

  // State register; reset discards any pending armed step.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state and pulse decision; halt overrides everything, including
  // a tick arriving in the same cycle.
  always_comb begin
    state_next_s = state_r;
    pulse_s      = 1'b0;
    if (halt) begin
      state_next_s = ST_HALTED;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (mode_run) begin
            state_next_s = ST_RUN;
          end else if (press_s) begin
            state_next_s = ST_ARMED;
          end else begin
            state_next_s = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (!mode_run) begin
            // Leaving run mode drops any tick of this cycle.
            state_next_s = ST_IDLE;
          end else if (tick_s) begin
            pulse_s      = 1'b1;
            state_next_s = ST_RUN;
          end else begin
            state_next_s = ST_RUN;
          end
        end
        ST_ARMED: begin
          if (mode_run) begin
            // Pending step is absorbed into free-run.
            state_next_s = ST_RUN;
          end else if (tick_s) begin
            pulse_s      = 1'b1;
            state_next_s = ST_IDLE;
          end else begin
            // Further presses while armed are ignored.
            state_next_s = ST_ARMED;
          end
        end
        ST_HALTED: begin
          state_next_s = ST_HALTED;
        end
        default: begin
          state_next_s = ST_IDLE;
        end
      endcase
    end
  end

  // Registered enable: a tick decided in cycle N drives cpu_en in cycle N+1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cpu_en_r <= 1'b0;
    end else begin
      cpu_en_r <= pulse_s;
    end
  end

  // Issued-step counter, updated on the same edge that raises cpu_en;
  // saturates instead of wrapping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      step_cnt_r <= CNT_ZERO;
    end else if (pulse_s && (step_cnt_r != CNT_MAX)) begin
      step_cnt_r <= step_cnt_r + CNT_ONE;
    end else begin
      step_cnt_r <= step_cnt_r;
    end
  end

  assign cpu_en   = cpu_en_r;
  assign state    = state_r;
  assign step_cnt = step_cnt_r;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Directed bench for cpu_step_ctrl with DEBOUNCE_CYCLES=4, CNT_W=4 and
// t from a divide-by-4 model (toggles every 2 clk).
module tb_cpu_step_ctrl;

  logic       clk      = 1'b0;
  logic       reset    = 1'b1;
  logic       mode_run = 1'b0;
  logic       step_btn = 1'b0;
  logic       halt     = 1'b0;
  logic [1:0] div      = 2'd0;
  logic       t;
  logic       cpu_en;
  logic [1:0] state;
  logic [3:0] step_cnt;

  int checks = 0;
  int errors = 0;

  cpu_step_ctrl #(
    .DEBOUNCE_CYCLES (4),
    .CNT_W           (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .t        (t),
    .mode_run (mode_run),
    .step_btn (step_btn),
    .halt     (halt),
    .cpu_en   (cpu_en),
    .state    (state),
    .step_cnt (step_cnt)
  );

  always #5 clk = ~clk;

  // Divider model: t toggles every 2 clk.
  always @(posedge clk) div <= div + 2'd1;
  assign t = div[1];

  task automatic do_reset;
    @(negedge clk);
    reset    = 1'b0;
    mode_run = 1'b0;
    step_btn = 1'b0;
    halt     = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (cpu_en !== 1'b0) begin errors++; $display("FAIL reset_cpu_en: got %b expected 0", cpu_en); end
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
    checks++; if (step_cnt !== 4'd0) begin errors++; $display("FAIL reset_step_cnt: got %0d expected 0", step_cnt); end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (state !== 2'd0 || cpu_en !== 1'b0) begin errors++; $display("FAIL reset_idle_after_release: state %0d cpu_en %b expected 0/0", state, cpu_en); end
  endtask

  task automatic test_run;
    int pulses = 0;
    int last = -1;
    int bad_width = 0;
    int bad_gap = 0;
    logic prev_en = 1'b0;
    do_reset();
    mode_run = 1'b1;
    @(negedge clk);
    checks++; if (state !== 2'd1 || cpu_en !== 1'b0) begin errors++; $display("FAIL run_entry: state %0d cpu_en %b expected 1/0", state, cpu_en); end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (cpu_en === 1'b1) begin
        pulses++;
        if (prev_en) bad_width++;
        if (last >= 0 && (i - last) != 4) bad_gap++;
        last = i;
      end
      prev_en = cpu_en;
    end
    checks++; if (pulses != 10) begin errors++; $display("FAIL run_pulse_count: got %0d expected 10", pulses); end
    checks++; if (bad_width != 0) begin errors++; $display("FAIL run_pulse_width: got %0d wide pulses expected 0", bad_width); end
    checks++; if (bad_gap != 0) begin errors++; $display("FAIL run_pulse_spacing: got %0d bad gaps expected 0", bad_gap); end
    checks++; if (step_cnt !== 4'd10) begin errors++; $display("FAIL run_step_cnt: got %0d expected 10", step_cnt); end
  endtask

  task automatic test_step;
    int pulses = 0;
    int bad_timing = 0;
    logic saw_armed = 1'b0;
    logic t_m1;
    logic t_m2 = 1'b1;
    logic [1:0] st_m1 = 2'd0;
    do_reset();
    t_m1 = t;
    step_btn = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (i == 10) step_btn = 1'b0;
      @(negedge clk);
      if (state === 2'd2) saw_armed = 1'b1;
      if (cpu_en === 1'b1) begin
        pulses++;
        if (!(t_m1 == 1'b1 && t_m2 == 1'b0 && st_m1 == 2'd2)) bad_timing++;
      end
      t_m2  = t_m1;
      t_m1  = t;
      st_m1 = state;
    end
    checks++; if (pulses != 1) begin errors++; $display("FAIL step_pulse_count: got %0d expected 1", pulses); end
    checks++; if (bad_timing != 0) begin errors++; $display("FAIL step_pulse_timing: got %0d misplaced expected 0", bad_timing); end
    checks++; if (saw_armed !== 1'b1) begin errors++; $display("FAIL step_armed_seen: got %b expected 1", saw_armed); end
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL step_final_state: got %0d expected 0", state); end
    checks++; if (step_cnt !== 4'd1) begin errors++; $display("FAIL step_step_cnt: got %0d expected 1", step_cnt); end
  endtask

  task automatic test_bounce;
    int iv [10] = '{1, 2, 3, 1, 2, 3, 2, 1, 3, 2};
    int bad_en = 0;
    int bad_state = 0;
    do_reset();
    step_btn = 1'b1;
    for (int k = 0; k < 10; k++) begin
      for (int j = 0; j < iv[k]; j++) begin
        @(negedge clk);
        if (cpu_en !== 1'b0) bad_en++;
        if (state !== 2'd0) bad_state++;
      end
      step_btn = ~step_btn;
    end
    step_btn = 1'b0;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      if (cpu_en !== 1'b0) bad_en++;
      if (state !== 2'd0) bad_state++;
    end
    checks++; if (bad_en != 0) begin errors++; $display("FAIL bounce_cpu_en: got %0d pulses expected 0", bad_en); end
    checks++; if (bad_state != 0) begin errors++; $display("FAIL bounce_state: got %0d non-idle cycles expected 0", bad_state); end
    checks++; if (step_cnt !== 4'd0) begin errors++; $display("FAIL bounce_step_cnt: got %0d expected 0", step_cnt); end
  endtask

  task automatic test_halt;
    logic tp;
    logic found = 1'b0;
    int bad = 0;
    do_reset();
    mode_run = 1'b1;
    tp = t;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (t == 1'b1 && tp == 1'b0 && state === 2'd1) begin
        found = 1'b1;
        break;
      end
      tp = t;
    end
    checks++; if (found !== 1'b1) begin errors++; $display("FAIL halt_tick_found: got %b expected 1", found); end
    halt = 1'b1;
    @(negedge clk);
    halt = 1'b0;
    checks++; if (cpu_en !== 1'b0) begin errors++; $display("FAIL halt_tick_dropped: got %b expected 0", cpu_en); end
    checks++; if (state !== 2'd3) begin errors++; $display("FAIL halt_state: got %0d expected 3", state); end
    for (int i = 0; i < 100; i++) begin
      if (i % 7 == 0) mode_run = ~mode_run;
      step_btn = ((i / 20) % 2) == 1;
      @(negedge clk);
      if (cpu_en !== 1'b0 || state !== 2'd3) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL halt_sticky: got %0d bad cycles expected 0", bad); end
    reset = 1'b0;
    #1;
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL halt_reset_state: got %0d expected 0", state); end
    mode_run = 1'b0;
    step_btn = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_saturation;
    int pulses = 0;
    int wraps = 0;
    logic [3:0] prev_cnt = 4'd0;
    do_reset();
    mode_run = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (cpu_en === 1'b1) pulses++;
      if (step_cnt < prev_cnt) wraps++;
      prev_cnt = step_cnt;
    end
    checks++; if (pulses != 20) begin errors++; $display("FAIL sat_pulse_count: got %0d expected 20", pulses); end
    checks++; if (step_cnt !== 4'd15) begin errors++; $display("FAIL sat_step_cnt: got %0d expected 15", step_cnt); end
    checks++; if (wraps != 0) begin errors++; $display("FAIL sat_no_wrap: got %0d wraps expected 0", wraps); end
  endtask

  task automatic test_async_reset;
    logic seen = 1'b0;
    int bad = 0;
    do_reset();
    mode_run = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cpu_en === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL areset_pulse_seen: got %b expected 1", seen); end
    reset = 1'b0;
    #1;
    checks++; if (cpu_en !== 1'b0) begin errors++; $display("FAIL areset_cpu_en: got %b expected 0", cpu_en); end
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL areset_state: got %0d expected 0", state); end
    checks++; if (step_cnt !== 4'd0) begin errors++; $display("FAIL areset_step_cnt: got %0d expected 0", step_cnt); end
    mode_run = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    // Arm a step, then reset while armed.
    seen = 1'b0;
    step_btn = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (state === 2'd2) begin
        seen = 1'b1;
        break;
      end
    end
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL areset_armed_seen: got %b expected 1", seen); end
    reset = 1'b0;
    step_btn = 1'b0;
    #1;
    checks++; if (state !== 2'd0 || cpu_en !== 1'b0) begin errors++; $display("FAIL areset_armed_clear: state %0d cpu_en %b expected 0/0", state, cpu_en); end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (cpu_en !== 1'b0 || state !== 2'd0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL areset_no_stray: got %0d bad cycles expected 0", bad); end
  endtask

  initial begin
    test_reset();
    test_run();
    test_step();
    test_bounce();
    test_halt();
    test_saturation();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
